stim_resp_harness: RTL and testbench
====================================

# stim_resp_harness

Self-checking stimulus/response harness for the generated combinational datapath blocks (7-bit `input_data` → 24-bit `output_data`). It drives pseudo-random vectors into the block's input from an LFSR and compacts the returned output words into a MISR signature. The result is one 24-bit value that is compared against a golden signature. It sits at the opposite end of the datapath interface: it is the producer of `input_data` and the consumer of `output_data`.

## Interface
- `IN_W`, 7, stimulus width; must equal the datapath input width.
- `OUT_W`, 24, response width; must equal the datapath output width.
- `LAT`, 0, datapath latency in cycles; legal range 0..3 (0 = purely combinational).
- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  terminate a run; returns to IDLE with no `done`.
- `seed`  in  IN_W  LFSR seed; captured on `start`; 0 is replaced by 1.
- `num_vec`  in  8  vectors per run; captured on `start`; 0 means 256.
- `stim_data`  out  IN_W  drives the datapath `input_data`.
- `resp_data`  in  OUT_W  from the datapath `output_data`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the signature becomes final.
- `signature`  out  OUT_W  MISR value; stable from `done` until the next `start`.

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE → IDLE.
- **IDLE:** on `start`:
  - load `lfsr` ← seed (or 1), `misr` ← 0, `remaining` ← num_vec.
  - next state is RUN.
- **RUN:**
  - `stim_data` = `lfsr`.
  - Each cycle: `lfsr` ← {lfsr[5:0], lfsr[6]^lfsr[5]} (x^7+x^6+1, period 127), and `remaining` decrements.
  - When the last vector is issued: go to DRAIN if LAT>0, else DONE.
- **DRAIN:**
  - `stim_data` holds the last vector.
  - Lasts exactly LAT cycles, waiting for the in-flight responses.
- **DONE:** `done`=1 for one cycle, then return to IDLE.
- Capture:
  - A LAT-deep valid shift register tags issued vectors.
  - A response is folded into the MISR in the cycle its tag emerges, so exactly num_vec responses are folded per run.
- MISR update (x^24+x^23+x^22+x^17+1):
  - fb = misr[23]^misr[22]^misr[21]^misr[16].
  - misr ← {misr[22:0], fb} ^ resp_data.
- `signature` = `misr` at all times. It is only meaningful when `done` is pulsing and until the next `start`.
- `start` while `busy`: ignored.
- `abort`:
  - In any non-IDLE state, go to IDLE next cycle.
  - Clears the valid pipe; no `done`.
  - `misr` holds its partial value.
  - `abort` has priority over every other transition.
- `start` and `abort` together in IDLE: `abort` wins; stay IDLE.
- LFSR wrap: runs longer than 127 vectors repeat the sequence. This is legal.

## Timing
- Reset (async, `rst_n`=0), all registers:
  - state=IDLE
  - `stim_data`=0
  - `busy`=0
  - `done`=0
  - `signature`=0
  - `lfsr`=0
  - `remaining`=0
  - valid pipe=0
- Reset mid-run: immediate return to the reset values; no `done`.
- Cycle after `start` (cycle S+1):
  - `busy`=1
  - `stim_data`=seed
- Vectors occupy cycles S+1 .. S+num_vec.
- `done` pulses in cycle S+num_vec+LAT+1, with `busy`=0 in that same cycle.
- Back-to-back runs: the next `start` is accepted in the cycle after `done`.
- `stim_data` outside RUN/DRAIN: holds its last value; 0 after reset.

## Structure
- Package `stim_resp_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - LFSR tap constants (bits 6,5)
  - MISR tap constants (bits 23,22,21,16)
  - default widths.
- Sub-module `sig_misr`:
  - parameterised OUT_W MISR with `clr`, `en`, `d`, `q`.
  - instantiated once.
- The LFSR, counter and FSM stay in the top level.

## Test plan
- Reset:
  - Assert `rst_n`=0 mid-RUN → all outputs 0 immediately, `done` never pulses.
  - After release, a `start` is accepted normally.
- Stimulus order: seed=7'h01, num_vec=8, LAT=0 → `stim_data` = 01,02,04,08,10,20,41,03 in cycles S+1..S+8; `done` pulses at S+9.
- MISR arithmetic: `resp_data` tied to 24'h000001:
  - num_vec=1 → `signature`=24'h000001.
  - num_vec=2 → `signature`=24'h000003.
- Latency: LAT=2, num_vec=3, `resp_data` = delayed stub, compared against the reference model → exactly 3 folds, `done` at S+6.
- Edge cases:
  - seed=0 → first vector 01.
  - num_vec=0 → 256 vectors, `done` at S+257, with the LFSR wrapping after 127.
- Control conflicts:
  - `start` during `busy` → ignored; no restart.
  - `abort` at cycle S+3 → IDLE at S+4, no `done`.
  - `start`+`abort` in IDLE → stays IDLE.

Source files
------------

// File: rtl/stim_resp_harness_pkg.sv
// Shared types and constants for the stimulus/response harness.
package stim_resp_pkg;

  localparam int unsigned IN_W_DEF  = 7;
  localparam int unsigned OUT_W_DEF = 24;
  localparam int unsigned NVEC_W    = 8;
  localparam int unsigned CNT_W     = NVEC_W + 1;

  // LFSR polynomial x^7 + x^6 + 1
  localparam int unsigned LFSR_TAP_HI = 6;
  localparam int unsigned LFSR_TAP_LO = 5;

  // MISR polynomial x^24 + x^23 + x^22 + x^17 + 1
  localparam int unsigned MISR_TAP_0 = 23;
  localparam int unsigned MISR_TAP_1 = 22;
  localparam int unsigned MISR_TAP_2 = 21;
  localparam int unsigned MISR_TAP_3 = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/stim_resp_harness_if.sv
// Control, stimulus and response signals between the harness and its
// controller/datapath. master = harness side, slave = environment side.
interface stim_resp_harness_if
  import stim_resp_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
);
  logic              start;
  logic              abort;
  logic [IN_W-1:0]   seed;
  logic [NVEC_W-1:0] num_vec;
  logic [IN_W-1:0]   stim_data;
  logic [OUT_W-1:0]  resp_data;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  signature;

  modport master (
    input  start, abort, seed, num_vec, resp_data,
    output stim_data, busy, done, signature
  );

  modport slave (
    output start, abort, seed, num_vec, resp_data,
    input  stim_data, busy, done, signature
  );
endinterface

// File: rtl/stim_resp_harness_sig_misr.sv
// Multiple-input signature register compacting datapath responses.
module sig_misr
  import stim_resp_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] d,
  output logic [OUT_W-1:0] q
);

  logic [OUT_W-1:0] misr_q;
  logic [OUT_W-1:0] misr_d;
  logic             fb;

  // Next signature: clear wins over fold, otherwise hold.
  always_comb begin
    fb     = misr_q[MISR_TAP_0] ^ misr_q[MISR_TAP_1] ^
             misr_q[MISR_TAP_2] ^ misr_q[MISR_TAP_3];
    misr_d = misr_q;
    if (clr) begin
      misr_d = '0;
    end else if (en) begin
      misr_d = {misr_q[OUT_W-2:0], fb} ^ d;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign q = misr_q;

endmodule

// File: rtl/stim_resp_harness.sv
// LFSR stimulus generator + MISR response compactor for a datapath with
// LAT cycles of latency (0..3). One run issues num_vec vectors and pulses
// done once the last response has been folded into the signature.
module stim_resp_harness
  import stim_resp_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned LAT   = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  stim_resp_harness_if.master bus
);

  localparam int unsigned VP_W = (LAT > 0) ? LAT : 1;

  state_e           state_q;
  logic [IN_W-1:0]  lfsr_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       drain_q;
  logic             busy_q;
  logic             done_q;
  logic [VP_W-1:0]  vp_q;
  logic [VP_W-1:0]  vp_d;
  logic [IN_W-1:0]  seed_eff;
  logic             abort_run;
  logic             accept;
  logic             fold;
  logic [OUT_W-1:0] misr_q;

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
    return {v[IN_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

  // Decode of run control: seed fix-up, abort qualification, start acceptance.
  always_comb begin
    seed_eff  = (bus.seed == '0) ? IN_W'(1) : bus.seed;
    abort_run = bus.abort && (state_q != ST_IDLE);
    accept    = (state_q == ST_IDLE) && bus.start && !bus.abort;
  end

  // Valid tags shadow issued vectors through the datapath latency.
  always_comb begin
    vp_d = '0;
    if (!abort_run) begin
      vp_d[0] = (state_q == ST_RUN);
      for (int unsigned i = 1; i < VP_W; i++) begin
        vp_d[i] = vp_q[i-1];
      end
    end
  end

  // Fold a response when its tag emerges; an aborting cycle leaves the MISR alone.
  always_comb begin
    fold = (LAT == 0) ? (state_q == ST_RUN) : vp_q[VP_W-1];
    if (abort_run) begin
      fold = 1'b0;
    end
  end

  // Valid tag pipe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_q <= '0;
    end else begin
      vp_q <= vp_d;
    end
  end

  // Run FSM with LFSR, vector counter, drain timer and registered outputs.
  // The LFSR register doubles as stim_data and is not stepped on the last
  // vector, so the final vector holds through DRAIN and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      rem_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_run) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        drain_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              lfsr_q  <= seed_eff;
              rem_q   <= (bus.num_vec == '0) ? CNT_W'(256) : {1'b0, bus.num_vec};
            end
          end
          ST_RUN: begin
            if (rem_q == CNT_W'(1)) begin
              rem_q <= '0;
              if (LAT == 0) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_DRAIN;
                drain_q <= 2'(LAT);
              end
            end else begin
              rem_q  <= rem_q - CNT_W'(1);
              lfsr_q <= lfsr_step(lfsr_q);
            end
          end
          ST_DRAIN: begin
            if (drain_q == 2'd1) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              drain_q <= '0;
            end else begin
              drain_q <= drain_q - 2'd1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  sig_misr #(
    .OUT_W(OUT_W)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (fold),
    .d    (bus.resp_data),
    .q    (misr_q)
  );

  assign bus.stim_data = lfsr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = misr_q;

endmodule

// File: tb/tb_stim_resp_harness.sv
// Bench for stim_resp_harness: two instances (LAT=0 and LAT=2) run in
// lock-step from shared controls, each fed by a stub datapath.
module tb_stim_resp_harness;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [6:0]  seed_r;
  logic [7:0]  nv_r;
  bit          tie_one;
  logic [23:0] p1, p2;
  int          tests;
  int          fails;

  stim_resp_harness_if #(.IN_W(7), .OUT_W(24)) if0 ();
  stim_resp_harness_if #(.IN_W(7), .OUT_W(24)) if2 ();

  stim_resp_harness #(.IN_W(7), .OUT_W(24), .LAT(0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0)
  );

  stim_resp_harness #(.IN_W(7), .OUT_W(24), .LAT(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: a nonlinear 7->24 bit mapping.
  function automatic logic [23:0] dp(input logic [6:0] x);
    logic [13:0] sq;
    sq = 14'(x) * 14'(x);
    return {x ^ 7'h55, sq, x[2:0]};
  endfunction

  assign if0.start     = start;
  assign if0.abort     = abort;
  assign if0.seed      = seed_r;
  assign if0.num_vec   = nv_r;
  assign if0.resp_data = tie_one ? 24'h000001 : dp(if0.stim_data);
  assign if2.start     = start;
  assign if2.abort     = abort;
  assign if2.seed      = seed_r;
  assign if2.num_vec   = nv_r;
  assign if2.resp_data = tie_one ? 24'h000001 : p2;

  initial begin
    p1 = '0;
    p2 = '0;
  end
  always @(posedge clk) begin
    p1 <= dp(if2.stim_data);
    p2 <= p1;
  end

  // Reference model pieces (polynomial arithmetic).
  function automatic logic [6:0] m_lfsr(input logic [6:0] v);
    return {v[5:0], ^(v & 7'h60)};
  endfunction

  function automatic logic [23:0] m_misr(input logic [23:0] m, input logic [23:0] r);
    return {m[22:0], ^(m & 24'hE10000)} ^ r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stim0"}, 32'(if0.stim_data), 0);
    chk({tag, "_busy0"}, 32'(if0.busy), 0);
    chk({tag, "_done0"}, 32'(if0.done), 0);
    chk({tag, "_sig0"},  32'(if0.signature), 0);
    chk({tag, "_stim2"}, 32'(if2.stim_data), 0);
    chk({tag, "_busy2"}, 32'(if2.busy), 0);
    chk({tag, "_done2"}, 32'(if2.done), 0);
    chk({tag, "_sig2"},  32'(if2.signature), 0);
  endtask

  // One run on both instances. restart_at/abort_at/rst_at (cycle offsets
  // after start, 0 = unused) inject control conflicts.
  task automatic run_check(input logic [6:0] sd, input logic [7:0] nv, input bit tie,
                           input int restart_at, input int abort_at, input int rst_at,
                           output logic [23:0] sig_out);
    logic [6:0]  vq[$];
    logic [6:0]  v;
    logic [23:0] m;
    logic [23:0] s0, s2;
    int          n, d0_at, d2_at, stop_at, limit;

    n = (nv == 0) ? 256 : int'(nv);
    v = (sd == 0) ? 7'h01 : sd;
    vq.delete();
    for (int i = 0; i < n; i++) begin
      vq.push_back(v);
      v = m_lfsr(v);
    end
    m = '0;
    foreach (vq[i]) m = m_misr(m, tie ? 24'h000001 : dp(vq[i]));

    d0_at = 0;
    d2_at = 0;
    s0 = '0;
    s2 = '0;
    stop_at = (abort_at > 0) ? abort_at : rst_at;
    limit = n + 6;
    tie_one = tie;
    seed_r = sd;
    nv_r = nv;
    start = 1'b1;
    step();
    start = 1'b0;

    for (int cyc = 1; cyc <= limit; cyc++) begin
      if ((stop_at == 0 || cyc <= stop_at) && cyc <= n) begin
        chk("stim0", 32'(if0.stim_data), 32'(vq[cyc-1]));
        chk("stim2", 32'(if2.stim_data), 32'(vq[cyc-1]));
        chk("busy0_run", 32'(if0.busy), 1);
        chk("busy2_run", 32'(if2.busy), 1);
      end
      if (if0.done && d0_at == 0) begin
        d0_at = cyc;
        s0 = if0.signature;
        chk("busy0_at_done", 32'(if0.busy), 0);
      end
      if (if2.done && d2_at == 0) begin
        d2_at = cyc;
        s2 = if2.signature;
        chk("busy2_at_done", 32'(if2.busy), 0);
      end
      if (cyc == restart_at) begin
        start = 1'b1;
        seed_r = ~sd;
        nv_r = nv + 8'd3;
      end
      if (cyc == abort_at) abort = 1'b1;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_midrun");
      end
      step();
      start = 1'b0;
      abort = 1'b0;
      if (cyc == abort_at) begin
        chk("abort_busy0", 32'(if0.busy), 0);
        chk("abort_busy2", 32'(if2.busy), 0);
        chk("abort_hold0", 32'(if0.stim_data), 32'(vq[cyc-1]));
        chk("abort_hold2", 32'(if2.stim_data), 32'(vq[cyc-1]));
      end
      if (cyc == rst_at) rst_n = 1'b1;
    end

    if (stop_at > 0) begin
      chk("no_done0", 32'(d0_at), 0);
      chk("no_done2", 32'(d2_at), 0);
    end else begin
      chk("done0_cycle", 32'(d0_at), 32'(n + 1));
      chk("done2_cycle", 32'(d2_at), 32'(n + 3));
      chk("sig0", 32'(s0), 32'(m));
      chk("sig2", 32'(s2), 32'(m));
      chk("sig0_stable", 32'(if0.signature), 32'(m));
      chk("sig2_stable", 32'(if2.signature), 32'(m));
    end
    sig_out = s0;
  endtask

  initial begin
    logic [23:0] sig;
    logic [6:0]  hold0;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seed_r = '0;
    nv_r = '0;
    tie_one = 1'b0;
    #3;
    chk_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed order check: seed 01, 8 vectors.
    run_check(7'h01, 8'd8, 1'b0, 0, 0, 0, sig);
    // MISR arithmetic with constant response 1.
    run_check(7'h2a, 8'd1, 1'b1, 0, 0, 0, sig);
    chk("sig_tie_n1", 32'(sig), 32'h000001);
    run_check(7'h2a, 8'd2, 1'b1, 0, 0, 0, sig);
    chk("sig_tie_n2", 32'(sig), 32'h000003);
    // Latency case (dut2 done at S+6) and seed=0 substitution.
    run_check(7'h33, 8'd3, 1'b0, 0, 0, 0, sig);
    run_check(7'h00, 8'd5, 1'b0, 0, 0, 0, sig);
    // 256-vector run wrapping the LFSR.
    run_check(7'h11, 8'd0, 1'b0, 0, 0, 0, sig);
    // Start while busy is ignored.
    run_check(7'h45, 8'd10, 1'b0, 3, 0, 0, sig);
    // Abort at S+3.
    run_check(7'h19, 8'd10, 1'b0, 0, 3, 0, sig);
    step();
    // Reset mid-run, then a normal run is accepted.
    run_check(7'h5c, 8'd12, 1'b0, 0, 0, 3, sig);
    run_check(7'h07, 8'd6, 1'b0, 0, 0, 0, sig);

    // start + abort together in IDLE: nothing starts.
    hold0 = if0.stim_data;
    seed_r = 7'h3c;
    nv_r = 8'd4;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_sa_busy0", 32'(if0.busy), 0);
    chk("idle_sa_busy2", 32'(if2.busy), 0);
    step();
    chk("idle_sa_stim0", 32'(if0.stim_data), 32'(hold0));
    chk("idle_sa_done0", 32'(if0.done), 0);

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      run_check(7'($urandom), 8'($urandom_range(1, 40)), 1'b0, 0, 0, 0, sig);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
